// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch stage feeding the main decoder. Owns the PC, issues word
// requests to instruction memory, buffers returned words in a small FIFO and
// hands them to decode with pre-sliced opcode/funct3 fields. A redirect
// reloads the PC, flushes the FIFO and discards in-flight responses.
//
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   imem_req_valid/ready: request handshake, imem_req_addr = current pc
//   imem_rsp_valid/data : in-order responses, one per accepted request
//   redirect/redirect_pc: taken branch/jump from execute
//   dec_valid/ready     : decode handshake on FIFO head
//   dec_instr/dec_pc    : head instruction and its PC (0 when FIFO empty)
//   dec_opcode/funct3   : dec_instr[6:0] / dec_instr[14:12]
// -----------------------------------------------------------------------------
module fetch_unit #(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
   parameter int              DEPTH    = 2
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [31:0]     imem_rsp_data,
   input  logic            redirect,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            dec_valid,
   input  logic            dec_ready,
   output logic [31:0]     dec_instr,
   output logic [XLEN-1:0] dec_pc,
   output logic [6:0]      dec_opcode,
   output logic [2:0]      dec_funct3
);

   localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW  = $clog2(DEPTH + 1);
   localparam int CW1 = CW + 1;
   localparam logic [PW-1:0]  LAST_PTR = PW'(DEPTH - 1);
   localparam logic [CW1-1:0] DEPTH_C  = CW1'(DEPTH);

   typedef enum logic [0:0] {RUN = 1'b0, DRAIN = 1'b1} state_t;

   state_t          state;
   state_t          state_nx;
   logic [XLEN-1:0] pc;
   logic [31:0]     fifo_instr [DEPTH];
   logic [XLEN-1:0] fifo_pc    [DEPTH];
   logic [PW-1:0]   rd_ptr;
   logic [PW-1:0]   wr_ptr;
   logic [CW-1:0]   count;
   // PCs of requests accepted but not yet answered, in issue order
   logic [XLEN-1:0] ipc_q [DEPTH];
   logic [PW-1:0]   iq_rd;
   logic [PW-1:0]   iq_wr;
   logic [CW-1:0]   out_cnt;
   logic [CW-1:0]   out_nx;
   logic [CW-1:0]   drop_cnt;
   logic [CW-1:0]   drop_nx;
   logic [CW1-1:0]  credit;
   logic            rsp;
   logic            pop;
   logic            push;
   logic            accept;
   logic            has_head;
   logic            unused_bits;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == LAST_PTR) ? {PW{1'b0}} : p + PW'(1'b1);
   endfunction

   // A response with nothing outstanding is a protocol error and is ignored
   assign rsp      = imem_rsp_valid & (out_cnt != {CW{1'b0}});
   assign has_head = (count != {CW{1'b0}});
   assign dec_valid = (state == RUN) & ~rst & has_head;
   assign pop      = dec_valid & dec_ready;
   // Slots in use after this cycle's pop; a new request needs a free slot
   assign credit   = {1'b0, count} + {1'b0, out_cnt} - {{CW{1'b0}}, pop};
   assign imem_req_valid = (state == RUN) & ~rst & (credit < DEPTH_C);
   assign accept   = imem_req_valid & imem_req_ready;
   assign imem_req_addr = pc;
   assign out_nx   = out_cnt + {{(CW-1){1'b0}}, accept} - {{(CW-1){1'b0}}, rsp};
   assign push     = rsp & (state == RUN) & ~redirect;

   assign dec_instr  = has_head ? fifo_instr[rd_ptr] : 32'h0000_0000;
   assign dec_pc     = has_head ? fifo_pc[rd_ptr] : {XLEN{1'b0}};
   assign dec_opcode = dec_instr[6:0];
   assign dec_funct3 = dec_instr[14:12];
   assign unused_bits = ^redirect_pc[1:0];

   // FSM state and stale-response counter register
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= RUN;
         drop_cnt <= {CW{1'b0}};
      end else begin
         state    <= state_nx;
         drop_cnt <= drop_nx;
      end
   end

   // Next state: redirect wins; DRAIN leaves once the last stale response lands
   always_comb begin
      state_nx = state;
      drop_nx  = drop_cnt;
      if (redirect) begin
         drop_nx  = out_nx;
         state_nx = (out_nx != {CW{1'b0}}) ? DRAIN : RUN;
      end else begin
         case (state)
            RUN: begin
               state_nx = RUN;
               drop_nx  = drop_cnt;
            end
            DRAIN: begin
               if (rsp) begin
                  drop_nx  = drop_cnt - CW'(1'b1);
                  state_nx = (drop_cnt == CW'(1'b1)) ? RUN : DRAIN;
               end else begin
                  drop_nx  = drop_cnt;
                  state_nx = DRAIN;
               end
            end
            default: begin
               state_nx = RUN;
               drop_nx  = {CW{1'b0}};
            end
         endcase
      end
   end

   // PC, FIFO pointers/count and in-flight tracking
   always_ff @(posedge clk) begin
      if (rst) begin
         pc      <= RESET_PC;
         rd_ptr  <= {PW{1'b0}};
         wr_ptr  <= {PW{1'b0}};
         count   <= {CW{1'b0}};
         iq_rd   <= {PW{1'b0}};
         iq_wr   <= {PW{1'b0}};
         out_cnt <= {CW{1'b0}};
      end else begin
         out_cnt <= out_nx;
         // Stale responses still retire their in-flight entry, keeping order
         if (accept) begin
            iq_wr <= ptr_inc(iq_wr);
         end
         if (rsp) begin
            iq_rd <= ptr_inc(iq_rd);
         end
         if (redirect) begin
            pc     <= {redirect_pc[XLEN-1:2], 2'b00};
            rd_ptr <= {PW{1'b0}};
            wr_ptr <= {PW{1'b0}};
            count  <= {CW{1'b0}};
         end else begin
            if (accept) begin
               pc <= pc + {{(XLEN-3){1'b0}}, 3'd4};
            end
            if (push) begin
               wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
               rd_ptr <= ptr_inc(rd_ptr);
            end
            count <= count + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};
         end
      end
   end

   // Storage arrays; contents are qualified by the pointers and need no reset
   always_ff @(posedge clk) begin
      if (accept) begin
         ipc_q[iq_wr] <= pc;
      end
      if (push) begin
         fifo_instr[wr_ptr] <= imem_rsp_data;
         fifo_pc[wr_ptr]    <= ipc_q[iq_rd];
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
// Directed bench for fetch_unit with a behavioural in-order instruction memory
// of configurable latency. Inputs change on the falling edge; observations are
// taken 1 time unit later, i.e. the exact values the next rising edge samples.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b0;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = 32'h0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        dec_valid;
   logic        dec_ready = 1'b0;
   logic [31:0] dec_instr;
   logic [31:0] dec_pc;
   logic [6:0]  dec_opcode;
   logic [2:0]  dec_funct3;

   always #5 clk = ~clk;

   fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
      .clk(clk), .rst(rst),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
      .imem_req_addr(imem_req_addr),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .redirect(redirect), .redirect_pc(redirect_pc),
      .dec_valid(dec_valid), .dec_ready(dec_ready),
      .dec_instr(dec_instr), .dec_pc(dec_pc),
      .dec_opcode(dec_opcode), .dec_funct3(dec_funct3)
   );

   int pass_cnt = 0;
   int total_cnt = 0;
   int cyc = 0;
   int lat = 1;
   int ready_mode = 0;
   int max_out = 0;

   logic        nxt_rst = 1'b1;
   logic        nxt_dec_ready = 1'b1;
   logic        nxt_redirect = 1'b0;
   logic [31:0] nxt_redirect_pc = 32'h0;

   logic [31:0] pend_addr[$];
   int          pend_due[$];

   logic        log_rv[$];
   logic        log_acc[$];
   logic        log_dv[$];
   logic [31:0] log_addr[$];
   logic [31:0] log_dpc[$];
   logic [31:0] log_dinstr[$];
   logic [6:0]  log_op[$];
   logic [2:0]  log_f3[$];
   logic [31:0] got_pc[$];
   logic [31:0] got_instr[$];

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return 32'h0050_0093 + (a << 8);
   endfunction

   // One clock cycle: apply inputs, run the memory model, log what the edge sees
   task automatic step();
      @(negedge clk);
      rst         = nxt_rst;
      dec_ready   = nxt_dec_ready;
      redirect    = nxt_redirect;
      redirect_pc = nxt_redirect_pc;
      imem_req_ready = (ready_mode == 0) || ((cyc % 2) == 0);
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
      if (!nxt_rst && pend_addr.size() > 0) begin
         if (pend_due[0] <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(pend_addr[0]);
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
         end
      end
      #1;
      log_rv.push_back(imem_req_valid);
      log_acc.push_back(imem_req_valid & imem_req_ready);
      log_addr.push_back(imem_req_addr);
      log_dv.push_back(dec_valid);
      log_dpc.push_back(dec_pc);
      log_dinstr.push_back(dec_instr);
      log_op.push_back(dec_opcode);
      log_f3.push_back(dec_funct3);
      if (imem_req_valid && imem_req_ready) begin
         pend_addr.push_back(imem_req_addr);
         pend_due.push_back(cyc + lat);
      end
      if (pend_addr.size() > max_out) max_out = pend_addr.size();
      if (dec_valid && dec_ready) begin
         got_pc.push_back(dec_pc);
         got_instr.push_back(dec_instr);
      end
      if (rst) begin
         pend_addr.delete();
         pend_due.delete();
      end
      cyc++;
   endtask

   task automatic clear_logs();
      log_rv.delete(); log_acc.delete(); log_addr.delete(); log_dv.delete();
      log_dpc.delete(); log_dinstr.delete(); log_op.delete(); log_f3.delete();
      got_pc.delete(); got_instr.delete();
      max_out = 0;
   endtask

   task automatic do_reset();
      nxt_rst = 1'b1;
      nxt_redirect = 1'b0;
      step();
      step();
      nxt_rst = 1'b0;
      clear_logs();
   endtask

   task automatic test_reset();
      clear_logs();
      lat = 1; ready_mode = 0; nxt_dec_ready = 1'b1; nxt_rst = 1'b1;
      for (int i = 0; i < 3; i++) step();
      total_cnt++;
      if (log_rv[2] !== 1'b0) $display("FAIL reset_req_valid: got %b expected 0", log_rv[2]); else pass_cnt++;
      total_cnt++;
      if (log_dv[2] !== 1'b0) $display("FAIL reset_dec_valid: got %b expected 0", log_dv[2]); else pass_cnt++;
      total_cnt++;
      if (log_dpc[2] !== 32'h0) $display("FAIL reset_dec_pc: got %h expected 0", log_dpc[2]); else pass_cnt++;
      total_cnt++;
      if (log_dinstr[2] !== 32'h0) $display("FAIL reset_dec_instr: got %h expected 0", log_dinstr[2]); else pass_cnt++;
      total_cnt++;
      if (log_addr[2] !== 32'h0) $display("FAIL reset_pc: got %h expected 0", log_addr[2]); else pass_cnt++;
   endtask

   task automatic test_stream();
      lat = 1; ready_mode = 0; nxt_dec_ready = 1'b1;
      do_reset();
      for (int i = 0; i < 8; i++) step();
      for (int i = 0; i < 6; i++) begin
         total_cnt++;
         if (log_acc[i] !== 1'b1 || log_addr[i] !== 32'(4 * i))
            $display("FAIL stream_req[%0d]: got acc=%b addr=%h expected acc=1 addr=%h", i, log_acc[i], log_addr[i], 32'(4 * i));
         else pass_cnt++;
      end
      for (int i = 0; i < 8; i++) begin
         total_cnt++;
         if (log_dv[i] !== (i >= 2) || (i >= 2 && log_dpc[i] !== 32'(4 * (i - 2))))
            $display("FAIL stream_dec[%0d]: got dv=%b pc=%h expected dv=%b pc=%h", i, log_dv[i], log_dpc[i], (i >= 2), 32'(4 * (i - 2)));
         else pass_cnt++;
      end
      total_cnt++;
      if (log_dinstr[2] !== 32'h0050_0093) $display("FAIL stream_instr: got %h expected 00500093", log_dinstr[2]); else pass_cnt++;
      total_cnt++;
      if (log_op[2] !== 7'h13) $display("FAIL stream_opcode: got %h expected 13", log_op[2]); else pass_cnt++;
      total_cnt++;
      if (log_f3[2] !== 3'h0) $display("FAIL stream_funct3: got %h expected 0", log_f3[2]); else pass_cnt++;
   endtask

   task automatic test_backpressure();
      lat = 1; ready_mode = 0;
      do_reset();
      nxt_dec_ready = 1'b0;
      for (int i = 0; i < 5; i++) step();
      nxt_dec_ready = 1'b1;
      for (int i = 0; i < 12; i++) step();
      total_cnt++;
      if (log_acc[0] !== 1'b1 || log_acc[1] !== 1'b1)
         $display("FAIL bp_fill: got acc0=%b acc1=%b expected 1 1", log_acc[0], log_acc[1]);
      else pass_cnt++;
      for (int i = 2; i < 5; i++) begin
         total_cnt++;
         if (log_rv[i] !== 1'b0 || log_dv[i] !== 1'b1 || log_dpc[i] !== 32'h0)
            $display("FAIL bp_hold[%0d]: got rv=%b dv=%b pc=%h expected rv=0 dv=1 pc=0", i, log_rv[i], log_dv[i], log_dpc[i]);
         else pass_cnt++;
      end
      total_cnt++;
      if (got_pc.size() != 12) $display("FAIL bp_count: got %0d expected 12", got_pc.size()); else pass_cnt++;
      for (int i = 0; i < 8 && i < got_pc.size(); i++) begin
         total_cnt++;
         if (got_pc[i] !== 32'(4 * i) || got_instr[i] !== mem_word(32'(4 * i)))
            $display("FAIL bp_order[%0d]: got pc=%h instr=%h expected pc=%h instr=%h", i, got_pc[i], got_instr[i], 32'(4 * i), mem_word(32'(4 * i)));
         else pass_cnt++;
      end
   endtask

   task automatic test_latency3_toggle();
      lat = 3; ready_mode = 1; nxt_dec_ready = 1'b1;
      do_reset();
      for (int i = 0; i < 40; i++) step();
      total_cnt++;
      if (max_out > 2) $display("FAIL lat3_outstanding: got %0d expected <=2", max_out); else pass_cnt++;
      total_cnt++;
      if (got_pc.size() < 5) $display("FAIL lat3_count: got %0d expected >=5", got_pc.size()); else pass_cnt++;
      for (int i = 0; i < 10 && i < got_pc.size(); i++) begin
         total_cnt++;
         if (got_pc[i] !== 32'(4 * i) || got_instr[i] !== mem_word(32'(4 * i)))
            $display("FAIL lat3_seq[%0d]: got pc=%h instr=%h expected pc=%h", i, got_pc[i], got_instr[i], 32'(4 * i));
         else pass_cnt++;
      end
      ready_mode = 0;
   endtask

   task automatic test_redirect_drain();
      lat = 3; ready_mode = 0; nxt_dec_ready = 1'b1;
      do_reset();
      step();
      step();
      nxt_redirect = 1'b1; nxt_redirect_pc = 32'h0000_0103;
      step();
      nxt_redirect = 1'b0;
      for (int i = 0; i < 8; i++) step();
      total_cnt++;
      if (log_acc[0] !== 1'b1 || log_acc[1] !== 1'b1 || log_rv[2] !== 1'b0)
         $display("FAIL rd_outstanding: got acc0=%b acc1=%b rv2=%b expected 1 1 0", log_acc[0], log_acc[1], log_rv[2]);
      else pass_cnt++;
      total_cnt++;
      if (log_rv[3] !== 1'b0 || log_rv[4] !== 1'b0 || log_dv[3] !== 1'b0 || log_dv[4] !== 1'b0)
         $display("FAIL rd_drain: got rv=%b%b dv=%b%b expected 00 00", log_rv[3], log_rv[4], log_dv[3], log_dv[4]);
      else pass_cnt++;
      total_cnt++;
      if (log_rv[5] !== 1'b1 || log_addr[5] !== 32'h0000_0100)
         $display("FAIL rd_new_addr: got rv=%b addr=%h expected rv=1 addr=00000100", log_rv[5], log_addr[5]);
      else pass_cnt++;
      total_cnt++;
      if (got_pc.size() != 2) $display("FAIL rd_got_count: got %0d expected 2", got_pc.size()); else pass_cnt++;
      if (got_pc.size() >= 2) begin
         total_cnt++;
         if (got_pc[0] !== 32'h100 || got_pc[1] !== 32'h104)
            $display("FAIL rd_got_pc: got %h %h expected 00000100 00000104", got_pc[0], got_pc[1]);
         else pass_cnt++;
      end
   endtask

   task automatic test_redirect_collide();
      lat = 1; ready_mode = 0; nxt_dec_ready = 1'b1;
      do_reset();
      for (int i = 0; i < 4; i++) step();
      nxt_redirect = 1'b1; nxt_redirect_pc = 32'h0000_0200;
      step();
      nxt_redirect = 1'b0;
      for (int i = 0; i < 5; i++) step();
      total_cnt++;
      if (log_acc[4] !== 1'b1 || log_addr[4] !== 32'h10)
         $display("FAIL col_accept: got acc=%b addr=%h expected acc=1 addr=00000010", log_acc[4], log_addr[4]);
      else pass_cnt++;
      total_cnt++;
      if (log_rv[5] !== 1'b0 || log_dv[5] !== 1'b0 || log_dv[6] !== 1'b0 || log_dv[7] !== 1'b0)
         $display("FAIL col_empty: got rv5=%b dv=%b%b%b expected 0 000", log_rv[5], log_dv[5], log_dv[6], log_dv[7]);
      else pass_cnt++;
      total_cnt++;
      if (log_rv[6] !== 1'b1 || log_addr[6] !== 32'h200)
         $display("FAIL col_restart: got rv=%b addr=%h expected rv=1 addr=00000200", log_rv[6], log_addr[6]);
      else pass_cnt++;
      total_cnt++;
      if (got_pc.size() != 5) $display("FAIL col_count: got %0d expected 5", got_pc.size()); else pass_cnt++;
      if (got_pc.size() == 5) begin
         total_cnt++;
         if (got_pc[2] !== 32'h8 || got_pc[3] !== 32'h200 || got_pc[4] !== 32'h204)
            $display("FAIL col_seq: got %h %h %h expected 00000008 00000200 00000204", got_pc[2], got_pc[3], got_pc[4]);
         else pass_cnt++;
      end
   endtask

   task automatic test_wrap_and_reset();
      lat = 1; ready_mode = 0; nxt_dec_ready = 1'b1;
      do_reset();
      step();
      nxt_redirect = 1'b1; nxt_redirect_pc = 32'hFFFF_FFFC;
      step();
      nxt_redirect = 1'b0;
      for (int i = 0; i < 3; i++) step();
      nxt_redirect = 1'b1; nxt_redirect_pc = 32'h0000_0040;
      step();
      nxt_redirect = 1'b0; nxt_rst = 1'b1;
      step();
      nxt_rst = 1'b0;
      step();
      total_cnt++;
      if (log_acc[3] !== 1'b1 || log_addr[3] !== 32'hFFFF_FFFC)
         $display("FAIL wrap_top: got acc=%b addr=%h expected acc=1 addr=fffffffc", log_acc[3], log_addr[3]);
      else pass_cnt++;
      total_cnt++;
      if (log_acc[4] !== 1'b1 || log_addr[4] !== 32'h0)
         $display("FAIL wrap_zero: got acc=%b addr=%h expected acc=1 addr=00000000", log_acc[4], log_addr[4]);
      else pass_cnt++;
      total_cnt++;
      if (got_pc.size() != 1 || got_pc[0] !== 32'hFFFF_FFFC)
         $display("FAIL wrap_dec: got n=%0d pc=%h expected n=1 pc=fffffffc", got_pc.size(), got_pc[0]);
      else pass_cnt++;
      total_cnt++;
      if (log_rv[6] !== 1'b0 || log_dv[6] !== 1'b0)
         $display("FAIL drain_rst: got rv=%b dv=%b expected 0 0", log_rv[6], log_dv[6]);
      else pass_cnt++;
      total_cnt++;
      if (log_rv[7] !== 1'b1 || log_addr[7] !== 32'h0)
         $display("FAIL rst_resume: got rv=%b addr=%h expected rv=1 addr=00000000", log_rv[7], log_addr[7]);
      else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_latency3_toggle();
      test_redirect_drain();
      test_redirect_collide();
      test_wrap_and_reset();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
